// File: rtl/mem_dump_tx.sv
// Purpose: dumps a range of 16-bit memory words as ASCII '0'/'1' text, MSB first, with an LF after each word.
// Latency: first read 1 cycle after start, first byte 3 cycles after start, 19 cycles per word when never stalled.
// Backpressure: out_valid/out_byte hold until out_ready; memory is read only after the previous LF is accepted.
module mem_dump_tx #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [7:0]        out_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_1  = 8'h31;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        SEND_BITS,
        SEND_NL,
        FIN
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W:0]     remaining;
    logic [DATA_W-1:0]   shift;
    logic [IDX_W-1:0]    bit_idx;
    logic                hs;

    assign hs = out_valid & out_ready;

    function automatic logic [7:0] bit_char(input logic b);
        return b ? ASCII_1 : ASCII_0;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            shift     <= '0;
            bit_idx   <= '0;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            out_byte  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr      <= base_addr;
                        remaining <= count;
                        busy      <= 1'b1;
                        if (count == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state     <= READ;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= base_addr;
                        end
                    end
                end
                READ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // Read data lands this cycle; present the MSB character straight away.
                    shift     <= mem_rd_data;
                    bit_idx   <= IDX_W'(DATA_W - 1);
                    out_byte  <= bit_char(mem_rd_data[DATA_W-1]);
                    out_valid <= 1'b1;
                    state     <= SEND_BITS;
                end
                SEND_BITS: begin
                    if (hs) begin
                        bit_idx <= bit_idx - 1'b1;
                        if (bit_idx == '0) begin
                            out_byte <= ASCII_LF;
                            state    <= SEND_NL;
                        end else begin
                            out_byte <= bit_char(shift[bit_idx - 1'b1]);
                        end
                    end
                end
                SEND_NL: begin
                    if (hs) begin
                        out_valid <= 1'b0;
                        addr      <= addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        // remaining still holds the pre-decrement value here.
                        if (remaining != {{ADDR_W{1'b0}}, 1'b1}) begin
                            state     <= READ;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= addr + 1'b1;
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dump_tx.sv
// Bench for mem_dump_tx: a text-level model builds the expected byte stream and read addresses
// from the memory image at start time; a negedge monitor compares every cycle.
module tb_mem_dump_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] base_addr;
    logic [16:0] count;
    logic [15:0] mem_addr;
    logic        mem_rd_en;
    logic [15:0] mem_rd_data;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    mem_dump_tx #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
        .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:65535];
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model state
    logic [7:0]  exp_q[$];
    logic [15:0] rd_q[$];
    logic [7:0]  got_q[$];
    logic [15:0] rdlog[$];
    bit   m_active = 0;
    bit   done_due = 0;
    bit   stall_prev = 0;
    bit   rst_prev = 0;
    logic [7:0] prev_byte;
    int   cyc = 0;
    int   acc_cyc = 0, done_cyc = 0, done_cnt = 0, first_rd_cyc = 0, first_valid_cyc = 0;
    bit   first_rd_pending = 0, first_valid_pending = 0;
    bit   rnd_ready = 0;

    always @(negedge clk) begin
        bit was_active;
        bit last_hs;
        cyc++;
        last_hs = 0;
        if (!rst_n) begin
            exp_q.delete();
            rd_q.delete();
            m_active = 0;
            done_due = 0;
            stall_prev = 0;
            rst_prev = 1;
        end else begin
            was_active = m_active;
            if (rst_prev) begin
                chk("post_reset_valid", out_valid, 0);
                chk("post_reset_busy", busy, 0);
                chk("post_reset_rden", mem_rd_en, 0);
                chk("post_reset_byte", out_byte, 0);
                chk("post_reset_addr", mem_addr, 0);
                rst_prev = 0;
            end
            chk("busy", busy, m_active);
            chk("done", done, done_due);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (mem_rd_en) begin
                if (rd_q.size() == 0) chk("spurious_read", mem_addr, 32'hdead);
                else chk("read_addr", mem_addr, rd_q.pop_front());
                rdlog.push_back(mem_addr);
                if (first_rd_pending) begin
                    first_rd_cyc = cyc;
                    first_rd_pending = 0;
                end
            end
            if (out_valid && first_valid_pending) begin
                first_valid_cyc = cyc;
                first_valid_pending = 0;
            end
            if (stall_prev) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_byte", out_byte, prev_byte);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("spurious_byte", out_byte, 32'hdead);
                else begin
                    chk("byte", out_byte, exp_q.pop_front());
                    if (exp_q.size() == 0) last_hs = 1;
                end
                got_q.push_back(out_byte);
            end
            stall_prev = out_valid && !out_ready;
            prev_byte  = out_byte;
            if (done_due) begin
                done_due = 0;
                m_active = 0;
            end
            if (last_hs) done_due = 1;
            if (!was_active && start) begin
                for (int i = 0; i < int'(count); i++) begin
                    logic [15:0] a;
                    logic [15:0] w;
                    a = base_addr + 16'(i);
                    w = mem[a];
                    rd_q.push_back(a);
                    for (int b = 15; b >= 0; b--) exp_q.push_back(w[b] ? 8'h31 : 8'h30);
                    exp_q.push_back(8'h0A);
                end
                m_active = 1;
                acc_cyc = cyc;
                first_rd_pending = 1;
                first_valid_pending = 1;
                if (count == 0) done_due = 1;
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] b, input logic [16:0] c);
        start = 1'b1;
        base_addr = b;
        count = c;
        tick(1);
        start = 1'b0;
        base_addr = 16'($urandom);
        count = 17'($urandom);
    endtask

    task automatic wait_done(input string name, input int bound);
        int n0;
        n0 = done_cnt;
        for (int i = 0; i < bound; i++) begin
            if (done_cnt > n0) break;
            tick(1);
        end
        chk(name, done_cnt > n0, 1);
        tick(2);
    endtask

    task automatic chk_text(input string name, input string s);
        int bad;
        bad = -1;
        for (int i = 0; i < s.len(); i++)
            if (bad < 0 && (i >= got_q.size() || got_q[i] !== s[i])) bad = i;
        if (bad < 0 && got_q.size() != s.len()) bad = s.len();
        nchk++;
        if (bad >= 0) begin
            nerr++;
            $display("FAIL %s: text differs at char %0d (got %0d chars, expected %0d)",
                     name, bad, got_q.size(), s.len());
        end
    endtask

    initial begin
        int n0;
        int nb;
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        count = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Basic dump
        mem[0] = 16'h3000;
        out_ready = 1'b1;
        got_q.delete();
        do_start(16'h0000, 17'd1);
        wait_done("basic_timeout", 100);
        chk_text("basic_text", "0011000000000000\n");
        chk("basic_done_lat", done_cyc - acc_cyc, 20);
        chk("basic_rd_lat", first_rd_cyc - acc_cyc, 1);
        chk("basic_valid_lat", first_valid_cyc - acc_cyc, 3);
        chk("basic_done_count", done_cnt, 1);

        // Multi-word with back-pressure
        mem[4] = 16'hFFFF;
        mem[5] = 16'h0001;
        got_q.delete();
        rnd_ready = 1;
        do_start(16'd4, 17'd2);
        wait_done("multi_timeout", 600);
        rnd_ready = 0;
        out_ready = 1'b1;
        chk_text("multi_text", "1111111111111111\n0000000000000001\n");

        // Zero count
        got_q.delete();
        rdlog.delete();
        do_start(16'd7, 17'd0);
        wait_done("zero_timeout", 10);
        chk("zero_done_lat", (done_cyc - acc_cyc >= 1) && (done_cyc - acc_cyc <= 2), 1);
        chk("zero_bytes", got_q.size(), 0);
        chk("zero_reads", rdlog.size(), 0);

        // Address wrap
        mem[16'hFFFF] = 16'hA5A5;
        mem[0] = 16'h5A5A;
        got_q.delete();
        rdlog.delete();
        do_start(16'hFFFF, 17'd2);
        wait_done("wrap_timeout", 100);
        chk("wrap_nreads", rdlog.size(), 2);
        if (rdlog.size() == 2) begin
            chk("wrap_rd0", rdlog[0], 16'hFFFF);
            chk("wrap_rd1", rdlog[1], 16'h0000);
        end
        chk_text("wrap_text", "1010010110100101\n0101101001011010\n");

        // Start while busy is ignored
        mem[10] = 16'h1234;
        mem[11] = 16'hABCD;
        got_q.delete();
        do_start(16'd10, 17'd2);
        tick(5);
        do_start(16'd20, 17'd5);
        wait_done("busy_start_timeout", 100);
        n0 = done_cnt;
        tick(60);
        chk("busy_start_bytes", got_q.size(), 34);
        chk("busy_start_no_extra_done", done_cnt, n0);
        chk_text("busy_start_text", "0001001000110100\n1010101111001101\n");

        // Reset mid-word aborts
        got_q.delete();
        do_start(16'd10, 17'd3);
        tick(8);
        n0 = done_cnt;
        nb = got_q.size();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(40);
        chk("rst_no_done", done_cnt, n0);
        chk("rst_no_bytes", got_q.size(), nb);

        // New start after reset
        got_q.delete();
        do_start(16'd4, 17'd1);
        wait_done("after_rst_timeout", 100);
        chk_text("after_rst_text", "1111111111111111\n");

        // Round trip: dump 8 words, parse the text back as the loader would
        for (int i = 0; i < 8; i++) mem[100 + i] = 16'($urandom);
        got_q.delete();
        rnd_ready = 1;
        do_start(16'd100, 17'd8);
        wait_done("rt_timeout", 800);
        rnd_ready = 0;
        out_ready = 1'b1;
        chk("rt_len", got_q.size(), 136);
        if (got_q.size() == 136) begin
            for (int w = 0; w < 8; w++) begin
                logic [15:0] v;
                v = '0;
                for (int b = 0; b < 16; b++) v = {v[14:0], got_q[w*17+b] == 8'h31};
                chk("rt_word", v, mem[100 + w]);
                chk("rt_lf", got_q[w*17+16], 8'h0A);
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish (errors=%0d)", nerr);
        $fatal(1, "timeout");
    end

endmodule
